// File: rtl/video_timing_ctrl.sv
// video_timing_ctrl: raster timing sequencer for the display path.
// A horizontal and a vertical phase FSM (VISIBLE, FRONT, SYNC, BACK), each with
// a phase-local down-counter, walk the position (h,v) over the full raster.
// All outputs are registered from the next-state values, so they always describe
// the position reached at the most recent advancing edge with no added latency.
// Optional feature: define VIDEO_TIMING_FRAME_COUNT_EN to add an 8-bit
// frame_count output that counts frame_start pulses (wraps 255->0).
// Every timing parameter must be >= 1, and H_TOTAL / V_TOTAL must fit in
// X_BITS / Y_BITS respectively.

module video_timing_ctrl #(
  parameter int H_VISIBLE       = 640,
  parameter int H_FRONT         = 16,
  parameter int H_SYNC          = 96,
  parameter int H_BACK          = 48,
  parameter int V_VISIBLE       = 480,
  parameter int V_FRONT         = 10,
  parameter int V_SYNC          = 2,
  parameter int V_BACK          = 33,
  parameter int X_BITS          = 10,
  parameter int Y_BITS          = 10,
  parameter int SYNC_ACTIVE_LOW = 1
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              pix_en,
  input  logic              resync,
  output logic              hsync,
  output logic              vsync,
  output logic              visible,
  output logic [X_BITS-1:0] x,
  output logic [Y_BITS-1:0] y,
  output logic              line_start,
  output logic              frame_start,
  output logic              vblank_start
`ifdef VIDEO_TIMING_FRAME_COUNT_EN
  ,
  output logic [7:0]        frame_count
`endif
);

  localparam int H_TOTAL = H_VISIBLE + H_FRONT + H_SYNC + H_BACK;
  localparam int V_TOTAL = V_VISIBLE + V_FRONT + V_SYNC + V_BACK;

  // The idle/pre-frame position is the very last pixel of the raster, so the
  // first advancing edge lands exactly on (0,0).
  localparam logic [X_BITS-1:0] H_LAST = X_BITS'(H_TOTAL - 1);
  localparam logic [Y_BITS-1:0] V_LAST = Y_BITS'(V_TOTAL - 1);

  // Pin levels for asserted / deasserted sync.
  localparam logic SYNC_ON  = (SYNC_ACTIVE_LOW != 0) ? 1'b0 : 1'b1;
  localparam logic SYNC_OFF = ~SYNC_ON;

  typedef enum logic [1:0] {
    PH_VISIBLE = 2'd0,
    PH_FRONT   = 2'd1,
    PH_SYNC    = 2'd2,
    PH_BACK    = 2'd3
  } phase_t;

  // Phase order shared by both axes.
  function automatic phase_t next_phase(input phase_t p);
    phase_t n;
    case (p)
      PH_VISIBLE: n = PH_FRONT;
      PH_FRONT:   n = PH_SYNC;
      PH_SYNC:    n = PH_BACK;
      default:    n = PH_VISIBLE;
    endcase
    return n;
  endfunction

  // Down-counter load value for a horizontal phase: its length minus one.
  function automatic logic [X_BITS-1:0] h_len_m1(input phase_t p);
    logic [X_BITS-1:0] n;
    case (p)
      PH_VISIBLE: n = X_BITS'(H_VISIBLE - 1);
      PH_FRONT:   n = X_BITS'(H_FRONT - 1);
      PH_SYNC:    n = X_BITS'(H_SYNC - 1);
      default:    n = X_BITS'(H_BACK - 1);
    endcase
    return n;
  endfunction

  // Down-counter load value for a vertical phase: its length minus one.
  function automatic logic [Y_BITS-1:0] v_len_m1(input phase_t p);
    logic [Y_BITS-1:0] n;
    case (p)
      PH_VISIBLE: n = Y_BITS'(V_VISIBLE - 1);
      PH_FRONT:   n = Y_BITS'(V_FRONT - 1);
      PH_SYNC:    n = Y_BITS'(V_SYNC - 1);
      default:    n = Y_BITS'(V_BACK - 1);
    endcase
    return n;
  endfunction

  // Current state.
  phase_t            h_phase;
  phase_t            v_phase;
  logic [X_BITS-1:0] h_pos;
  logic [Y_BITS-1:0] v_pos;
  logic [X_BITS-1:0] h_cnt;
  logic [Y_BITS-1:0] v_cnt;

  // Next state.
  phase_t            h_phase_n;
  phase_t            v_phase_n;
  logic [X_BITS-1:0] h_pos_n;
  logic [Y_BITS-1:0] v_pos_n;
  logic [X_BITS-1:0] h_cnt_n;
  logic [Y_BITS-1:0] v_cnt_n;

  // Events produced by the advancing edge.
  logic line_wrap;
  logic frame_wrap;
  logic vblank_hit;

  // Next output values.
  logic              hsync_n;
  logic              vsync_n;
  logic              visible_n;
  logic [X_BITS-1:0] x_n;
  logic [Y_BITS-1:0] y_n;

  // Horizontal FSM: step one pixel per pix_en edge, change phase when the
  // phase-local counter has consumed the phase's last pixel.
  always_comb begin
    h_phase_n = h_phase;
    h_pos_n   = h_pos;
    h_cnt_n   = h_cnt;
    line_wrap = 1'b0;
    if (resync) begin
      h_phase_n = PH_BACK;
      h_pos_n   = H_LAST;
      h_cnt_n   = '0;
    end else if (pix_en) begin
      if (h_cnt == '0) begin
        h_phase_n = next_phase(h_phase);
        h_cnt_n   = h_len_m1(next_phase(h_phase));
        if (h_phase == PH_BACK) begin
          h_pos_n   = '0;
          line_wrap = 1'b1;
        end else begin
          h_pos_n = h_pos + X_BITS'(1);
        end
      end else begin
        h_cnt_n = h_cnt - X_BITS'(1);
        h_pos_n = h_pos + X_BITS'(1);
      end
    end
  end

  // Vertical FSM: identical phase walk, stepped once per horizontal wrap.
  always_comb begin
    v_phase_n  = v_phase;
    v_pos_n    = v_pos;
    v_cnt_n    = v_cnt;
    frame_wrap = 1'b0;
    vblank_hit = 1'b0;
    if (resync) begin
      v_phase_n = PH_BACK;
      v_pos_n   = V_LAST;
      v_cnt_n   = '0;
    end else if (line_wrap) begin
      if (v_cnt == '0) begin
        v_phase_n = next_phase(v_phase);
        v_cnt_n   = v_len_m1(next_phase(v_phase));
        if (v_phase == PH_BACK) begin
          v_pos_n    = '0;
          frame_wrap = 1'b1;
        end else begin
          v_pos_n = v_pos + Y_BITS'(1);
        end
        if (v_phase == PH_VISIBLE) begin
          vblank_hit = 1'b1;
        end
      end else begin
        v_cnt_n = v_cnt - Y_BITS'(1);
        v_pos_n = v_pos + Y_BITS'(1);
      end
    end
  end

  // Decode the next-state phases into the pin values for the next position.
  always_comb begin
    visible_n = (h_phase_n == PH_VISIBLE) && (v_phase_n == PH_VISIBLE);
    hsync_n   = (h_phase_n == PH_SYNC) ? SYNC_ON : SYNC_OFF;
    vsync_n   = (v_phase_n == PH_SYNC) ? SYNC_ON : SYNC_OFF;
    x_n       = visible_n ? h_pos_n : '0;
    y_n       = visible_n ? v_pos_n : '0;
  end

  // State register for both FSMs and their counters.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      h_phase <= PH_BACK;
      v_phase <= PH_BACK;
      h_pos   <= H_LAST;
      v_pos   <= V_LAST;
      h_cnt   <= '0;
      v_cnt   <= '0;
    end else begin
      h_phase <= h_phase_n;
      v_phase <= v_phase_n;
      h_pos   <= h_pos_n;
      v_pos   <= v_pos_n;
      h_cnt   <= h_cnt_n;
      v_cnt   <= v_cnt_n;
    end
  end

  // Output register; strobes only live for the single clk after an advance.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      hsync        <= SYNC_OFF;
      vsync        <= SYNC_OFF;
      visible      <= 1'b0;
      x            <= '0;
      y            <= '0;
      line_start   <= 1'b0;
      frame_start  <= 1'b0;
      vblank_start <= 1'b0;
    end else begin
      hsync        <= hsync_n;
      vsync        <= vsync_n;
      visible      <= visible_n;
      x            <= x_n;
      y            <= y_n;
      line_start   <= line_wrap;
      frame_start  <= frame_wrap;
      vblank_start <= vblank_hit;
    end
  end

`ifdef VIDEO_TIMING_FRAME_COUNT_EN
  // Count frame starts; survives resync, cleared only by rst.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      frame_count <= 8'd0;
    end else if (frame_wrap) begin
      frame_count <= frame_count + 8'd1;
    end
  end
`else
  // No frame counter in this build.
`endif

endmodule

// File: tb/tb_video_timing_ctrl.sv
// tb_video_timing_ctrl: self-checking bench for video_timing_ctrl using a small
// 8x6 raster. Expected values come from a position-level reference model:
// (h,v) as plain integers, region membership by arithmetic on the timing
// parameters. Set VIDEO_TIMING_FRAME_COUNT_EN to also exercise frame_count.

module tb_video_timing_ctrl;

  localparam int HV = 4;
  localparam int HF = 1;
  localparam int HS = 2;
  localparam int HB = 1;
  localparam int VV = 3;
  localparam int VF = 1;
  localparam int VS = 1;
  localparam int VB = 1;
  localparam int HT = HV + HF + HS + HB;
  localparam int VT = VV + VF + VS + VB;

  logic       clk;
  logic       rst;
  logic       pix_en;
  logic       resync;
  logic       hsync;
  logic       vsync;
  logic       visible;
  logic [9:0] x;
  logic [9:0] y;
  logic       line_start;
  logic       frame_start;
  logic       vblank_start;
`ifdef VIDEO_TIMING_FRAME_COUNT_EN
  logic [7:0] frame_count;
`endif

  int checks = 0;
  int errors = 0;

  // Reference model state.
  int         m_h;
  int         m_v;
  logic       e_ls;
  logic       e_fs;
  logic       e_vbs;
  logic [7:0] m_fc;

  video_timing_ctrl #(
    .H_VISIBLE(HV), .H_FRONT(HF), .H_SYNC(HS), .H_BACK(HB),
    .V_VISIBLE(VV), .V_FRONT(VF), .V_SYNC(VS), .V_BACK(VB),
    .X_BITS(10), .Y_BITS(10), .SYNC_ACTIVE_LOW(1)
  ) dut (
    .clk(clk),
    .rst(rst),
    .pix_en(pix_en),
    .resync(resync),
    .hsync(hsync),
    .vsync(vsync),
    .visible(visible),
    .x(x),
    .y(y),
    .line_start(line_start),
    .frame_start(frame_start),
    .vblank_start(vblank_start)
`ifdef VIDEO_TIMING_FRAME_COUNT_EN
    ,
    .frame_count(frame_count)
`endif
  );

  // Free-running clock.
  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic checkValue(input string tag, input logic [31:0] obs, input logic [31:0] expv);
    checks++;
    assert (obs === expv) else begin
      errors++;
      $error("[TB] FAIL %s observed=%0h expected=%0h", tag, obs, expv);
    end
  endtask

  task automatic modelReset(input logic clear_count);
    m_h   = HT - 1;
    m_v   = VT - 1;
    e_ls  = 1'b0;
    e_fs  = 1'b0;
    e_vbs = 1'b0;
    if (clear_count) m_fc = 8'd0;
  endtask

  // Compare every output against the model's view of the current position.
  task automatic checkOutput(input string tag);
    logic       e_vis;
    logic       e_hs;
    logic       e_vs;
    logic [9:0] e_x;
    logic [9:0] e_y;
    e_vis = (m_h < HV) && (m_v < VV);
    e_hs  = (m_h >= HV + HF && m_h < HV + HF + HS) ? 1'b0 : 1'b1;
    e_vs  = (m_v >= VV + VF && m_v < VV + VF + VS) ? 1'b0 : 1'b1;
    e_x   = e_vis ? 10'(m_h) : 10'd0;
    e_y   = e_vis ? 10'(m_v) : 10'd0;
    checkValue({tag, ".visible"}, 32'(visible), 32'(e_vis));
    checkValue({tag, ".hsync"}, 32'(hsync), 32'(e_hs));
    checkValue({tag, ".vsync"}, 32'(vsync), 32'(e_vs));
    checkValue({tag, ".x"}, 32'(x), 32'(e_x));
    checkValue({tag, ".y"}, 32'(y), 32'(e_y));
    checkValue({tag, ".line_start"}, 32'(line_start), 32'(e_ls));
    checkValue({tag, ".frame_start"}, 32'(frame_start), 32'(e_fs));
    checkValue({tag, ".vblank_start"}, 32'(vblank_start), 32'(e_vbs));
`ifdef VIDEO_TIMING_FRAME_COUNT_EN
    checkValue({tag, ".frame_count"}, 32'(frame_count), 32'(m_fc));
`endif
  endtask

  // Drive one clk cycle (from a negedge), update the model, return at the next negedge.
  task automatic applyStimulus(input logic en, input logic rs);
    pix_en = en;
    resync = rs;
    @(posedge clk);
    e_ls  = 1'b0;
    e_fs  = 1'b0;
    e_vbs = 1'b0;
    if (rs) begin
      modelReset(1'b0);
    end else if (en) begin
      m_h = (m_h + 1) % HT;
      if (m_h == 0) m_v = (m_v + 1) % VT;
      e_ls  = (m_h == 0);
      e_fs  = (m_h == 0) && (m_v == 0);
      e_vbs = (m_h == 0) && (m_v == VV);
      if (e_fs) m_fc = m_fc + 8'd1;
    end
    @(negedge clk);
  endtask

  // Asynchronous reset between clock edges, checked before the next edge.
  task automatic asyncReset(input string tag);
    #2 rst = 1'b1;
    #1;
    modelReset(1'b1);
    checkOutput(tag);
    @(negedge clk);
    rst = 1'b0;
  endtask

  initial begin
    int hs_low;
    int vs_low;
    int ls_cnt;
    int fs_cnt;
    int vb_cnt;
    logic reached;

    rst    = 1'b1;
    pix_en = 1'b0;
    resync = 1'b0;
    modelReset(1'b1);

    // Reset state.
    @(negedge clk);
    @(negedge clk);
    checkOutput("reset");
    rst = 1'b0;

    // First frame with pix_en held high: 48 edges from the pre-frame position.
    hs_low = 0;
    vs_low = 0;
    ls_cnt = 0;
    fs_cnt = 0;
    vb_cnt = 0;
    for (int i = 0; i < HT * VT; i++) begin
      applyStimulus(1'b1, 1'b0);
      checkOutput("frame");
      if (hsync == 1'b0) hs_low++;
      if (vsync == 1'b0) vs_low++;
      if (line_start == 1'b1) ls_cnt++;
      if (frame_start == 1'b1) fs_cnt++;
      if (vblank_start == 1'b1) vb_cnt++;
    end
    checkValue("frame.hsync_low_pixels", 32'(hs_low), 32'd12);
    checkValue("frame.vsync_low_pixels", 32'(vs_low), 32'd8);
    checkValue("frame.line_starts", 32'(ls_cnt), 32'd6);
    checkValue("frame.frame_starts", 32'(fs_cnt), 32'd1);
    checkValue("frame.vblank_starts", 32'(vb_cnt), 32'd1);

    // Edge 49 starts the next frame.
    applyStimulus(1'b1, 1'b0);
    checkOutput("edge49");
    checkValue("edge49.frame_start_direct", 32'(frame_start), 32'd1);

    // Run to the end of line 0, then pix_en 1,0,0,1.
    for (int i = 0; i < HT - 1; i++) begin
      applyStimulus(1'b1, 1'b0);
      checkOutput("line0");
    end
    applyStimulus(1'b1, 1'b0);
    checkOutput("toggle.edge");
    checkValue("toggle.line_start_direct", 32'(line_start), 32'd1);
    applyStimulus(1'b0, 1'b0);
    checkOutput("toggle.low1");
    checkValue("toggle.strobe_cleared", 32'(line_start), 32'd0);
    applyStimulus(1'b0, 1'b0);
    checkOutput("toggle.low2");
    applyStimulus(1'b1, 1'b0);
    checkOutput("toggle.resume");

    // Walk to (2,1), then resync together with pix_en.
    reached = (m_h == 2) && (m_v == 1);
    for (int i = 0; i < 2 * HT * VT && !reached; i++) begin
      applyStimulus(1'b1, 1'b0);
      checkOutput("seek");
      reached = (m_h == 2) && (m_v == 1);
    end
    checkValue("seek.reached_2_1", 32'(reached), 32'd1);
    applyStimulus(1'b1, 1'b1);
    checkOutput("resync");
    checkValue("resync.visible_direct", 32'(visible), 32'd0);
    applyStimulus(1'b1, 1'b0);
    checkOutput("after_resync");
    checkValue("after_resync.frame_start_direct", 32'(frame_start), 32'd1);

    // Randomized pix_en with occasional resync.
    for (int i = 0; i < 600; i++) begin
      applyStimulus(($urandom % 4) != 0, ($urandom % 61) == 0);
      checkOutput("random");
    end

    // Asynchronous reset mid-frame, then restart.
    for (int i = 0; i < 13; i++) begin
      applyStimulus(1'b1, 1'b0);
      checkOutput("pre_rst");
    end
    asyncReset("async_rst");
    applyStimulus(1'b1, 1'b0);
    checkOutput("post_rst");

`ifdef VIDEO_TIMING_FRAME_COUNT_EN
    // 257 frame starts from reset wrap the counter back to 1.
    asyncReset("fc.rst");
    for (int i = 0; i < 1 + 256 * HT * VT; i++) begin
      applyStimulus(1'b1, 1'b0);
      checkOutput("fc.run");
    end
    checkValue("fc.after_wrap", 32'(frame_count), 32'd1);
    for (int i = 0; i < 20; i++) begin
      applyStimulus(1'b1, 1'b0);
      checkOutput("fc.mid");
    end
    asyncReset("fc.mid_rst");
    checkValue("fc.cleared", 32'(frame_count), 32'd0);
`endif

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
